// File: rtl/dbn_pkg.sv
// Shared constants, Q1.15 limits and FSM state type for the DBN neuron datapath.
package dbn_pkg;

  localparam int PROD_W = 32;
  localparam int OUT_W  = 16;
  localparam int GUARD  = 8;
  localparam int ACC_W  = PROD_W + GUARD;
  localparam int CNT_W  = 9;

  localparam logic [OUT_W-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [OUT_W-1:0] Q15_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/round_sat_q15.sv
// Combinational Q.31 accumulator to Q1.15 conversion: round half up,
// then clamp to the Q1.15 range and flag when clamping happened.
module round_sat_q15
  import dbn_pkg::*;
#(
  parameter int IN_W = ACC_W
) (
  input  logic [IN_W-1:0]  i_acc,
  output logic [OUT_W-1:0] o_y,
  output logic             o_sat
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam logic signed [IN_W:0] HALF_LSB = {{(IN_W-15){1'b0}}, 1'b1, 15'd0};
  localparam logic signed [IN_W:0] R_MAX    = {{(IN_W-14){1'b0}}, 15'h7FFF};
  localparam logic signed [IN_W:0] R_MIN    = {{(IN_W-14){1'b1}}, 15'h0000};

  logic signed [IN_W:0] w_sum;
  logic signed [IN_W:0] w_shift;

  assign w_sum   = $signed({i_acc[IN_W-1], i_acc}) + HALF_LSB;
  assign w_shift = w_sum >>> 16;

  // Clamp the rounded value into Q1.15 and report saturation.
  always_comb begin
    o_y   = w_shift[OUT_W-1:0];
    o_sat = 1'b0;
    if (w_shift > R_MAX) begin
      o_y   = Q15_MAX;
      o_sat = 1'b1;
    end else if (w_shift < R_MIN) begin
      o_y   = Q15_MIN;
      o_sat = 1'b1;
    end else begin
      o_y   = w_shift[OUT_W-1:0];
      o_sat = 1'b0;
    end
  end

endmodule

// File: rtl/neuron_accum.sv
// Neuron pre-activation accumulator: bias-seeded sum of n_terms Q1.31
// products in a guard-banded accumulator, emitted as a rounded, saturated
// Q1.15 result through a valid/ready handshake.
module neuron_accum
  import dbn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic [OUT_W-1:0]  bias_in,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_in,
  output logic              prod_ready,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [OUT_W-1:0]  y_out,
  output logic              y_sat,
  output logic              busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_n_lat;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_last_prod;
  logic               r_y_valid;
  logic [OUT_W-1:0]   r_y_out;
  logic               r_y_sat;
  logic [OUT_W-1:0]   w_rs_y;
  logic               w_rs_sat;

  assign w_cnt_inc   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_last_prod = (w_cnt_inc == r_n_lat);

  round_sat_q15 #(.IN_W(ACC_W)) u_round_sat (
    .i_acc (r_acc),
    .o_y   (w_rs_y),
    .o_sat (w_rs_sat)
  );

  // Next-state logic; nothing advances while the clock enable is low.
  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt = (n_terms != {CNT_W{1'b0}}) ? ACC : FIN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        ACC: begin
          if (prod_valid && w_last_prod) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = ACC;
          end
        end
        FIN: w_state_nxt = OUT;
        OUT: begin
          if (y_ready) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = OUT;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, term counter and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= {ACC_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_n_lat   <= {CNT_W{1'b0}};
      r_y_valid <= 1'b0;
      r_y_out   <= {OUT_W{1'b0}};
      r_y_sat   <= 1'b0;
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Q1.15 bias aligned to the Q.31 accumulator binary point.
            r_acc   <= {{(ACC_W-OUT_W-16){bias_in[OUT_W-1]}}, bias_in, 16'd0};
            r_n_lat <= n_terms;
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        ACC: begin
          if (prod_valid) begin
            r_acc <= r_acc + {{GUARD{prod_in[PROD_W-1]}}, prod_in};
            r_cnt <= w_cnt_inc;
          end
        end
        FIN: begin
          r_y_out   <= w_rs_y;
          r_y_sat   <= w_rs_sat;
          r_y_valid <= 1'b1;
        end
        OUT: begin
          if (y_ready) begin
            r_y_valid <= 1'b0;
          end
        end
        default: begin
          r_y_valid <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = en && (r_state == ACC);
  assign busy       = (r_state != IDLE);
  assign y_valid    = r_y_valid;
  assign y_out      = r_y_out;
  assign y_sat      = r_y_sat;

endmodule

// File: tb/tb_neuron_accum.sv
// Self-checking bench for neuron_accum: directed scenarios plus randomized
// jobs checked against an arithmetic reference model.
module tb_neuron_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [8:0]  n_terms;
  logic [15:0] bias_in;
  logic        prod_valid;
  logic [31:0] prod_in;
  logic        prod_ready;
  logic        y_valid;
  logic        y_ready;
  logic [15:0] y_out;
  logic        y_sat;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] prod_q[$];

  neuron_accum dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .n_terms(n_terms),
    .bias_in(bias_in), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(prod_ready), .y_valid(y_valid), .y_ready(y_ready),
    .y_out(y_out), .y_sat(y_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Real-valued rule: bias*2^16 + sum(products), round half up, clamp.
  function automatic void ref_model(input logic [15:0] bias, output logic [15:0] y, output logic s);
    longint tot;
    longint r;
    tot = longint'($signed(bias)) * 64'sd65536;
    foreach (prod_q[i]) tot += longint'($signed(prod_q[i]));
    r = (tot + 64'sd32768) >>> 16;
    if (r > 64'sd32767) begin
      y = 16'h7FFF; s = 1'b1;
    end else if (r < -64'sd32768) begin
      y = 16'h8000; s = 1'b1;
    end else begin
      y = r[15:0]; s = 1'b0;
    end
  endfunction

  // Drive one job from prod_q; lat counts cycles from the last accepted
  // term (or start) to y_valid. Optionally consume the result.
  task automatic run_job(input logic [15:0] bias, input bit bubbles, input bit consume,
                         output int lat, output logic [15:0] y, output logic s);
    int n;
    n = prod_q.size();
    start = 1'b1; n_terms = 9'(n); bias_in = bias;
    lat = 0;
    if (n == 0) begin
      tick(); start = 1'b0; lat = 1;
    end else begin
      tick(); start = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (bubbles) begin
          repeat ($urandom_range(0, 2)) begin prod_valid = 1'b0; tick(); end
        end
        prod_valid = 1'b1; prod_in = prod_q[i];
        tick();
      end
      prod_valid = 1'b0; lat = 1;
    end
    while (!y_valid && lat < 40) begin tick(); lat++; end
    y = y_out; s = y_sat;
    if (consume) begin
      y_ready = 1'b1; tick(); y_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    n_cmp++; if (y_out !== 16'h0000) begin n_err++; $display("FAIL reset_y_out: got %h expected 0000", y_out); end
    n_cmp++; if (y_sat !== 1'b0) begin n_err++; $display("FAIL reset_y_sat: got %b expected 0", y_sat); end
    n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL reset_prod_ready: got %b expected 0", prod_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int lat; logic [15:0] y, ey; logic s, es;
    prod_q = {32'h20000000, 32'hE0000000};
    ref_model(16'h1000, ey, es);
    run_job(16'h1000, 1'b0, 1'b1, lat, y, s);
    n_cmp++; if (y !== ey) begin n_err++; $display("FAIL basic_y: got %h expected %h", y, ey); end
    n_cmp++; if (s !== es) begin n_err++; $display("FAIL basic_sat: got %b expected %b", s, es); end
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_drop: got %b expected 0", busy); end
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] y, ey; logic s, es;
    prod_q = {32'h40000000, 32'h40000000, 32'h40000000};
    ref_model(16'h0000, ey, es);
    run_job(16'h0000, 1'b0, 1'b1, lat, y, s);
    n_cmp++; if (y !== ey || s !== es) begin n_err++; $display("FAIL sat_pos: got %h/%b expected %h/%b", y, s, ey, es); end
    prod_q = {32'hC0000000, 32'hC0000000, 32'hC0000000};
    ref_model(16'h0000, ey, es);
    run_job(16'h0000, 1'b0, 1'b1, lat, y, s);
    n_cmp++; if (y !== ey || s !== es) begin n_err++; $display("FAIL sat_neg: got %h/%b expected %h/%b", y, s, ey, es); end
  endtask

  task automatic test_rounding();
    int lat; logic [15:0] y, ey; logic s, es;
    logic [31:0] cases [3] = '{32'h00008000, 32'hFFFF8000, 32'hFFFF7FFF};
    for (int i = 0; i < 3; i++) begin
      prod_q = {cases[i]};
      ref_model(16'h0000, ey, es);
      run_job(16'h0000, 1'b0, 1'b1, lat, y, s);
      n_cmp++; if (y !== ey || s !== es) begin n_err++; $display("FAIL round_%0d: got %h/%b expected %h/%b", i, y, s, ey, es); end
    end
  endtask

  task automatic test_zero_terms();
    logic [15:0] ey; logic es;
    prod_q = {};
    ref_model(16'hC000, ey, es);
    start = 1'b1; n_terms = 9'd0; bias_in = 16'hC000;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_in = $urandom;
    n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL zero_prod_ready_fin: got %b expected 0", prod_ready); end
    n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL zero_early_valid: got %b expected 0", y_valid); end
    tick();
    n_cmp++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL zero_latency: got %b expected 1", y_valid); end
    n_cmp++; if (y_out !== ey || y_sat !== es) begin n_err++; $display("FAIL zero_y: got %h/%b expected %h/%b", y_out, y_sat, ey, es); end
    n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL zero_prod_ready_out: got %b expected 0", prod_ready); end
    y_ready = 1'b1; tick(); y_ready = 1'b0; prod_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] y, ey; logic s, es;
    prod_q = {32'($urandom), 32'($urandom)};
    ref_model(16'h0123, ey, es);
    run_job(16'h0123, 1'b0, 1'b0, lat, y, s);
    n_cmp++; if (y !== ey || s !== es) begin n_err++; $display("FAIL bp_y: got %h/%b expected %h/%b", y, s, ey, es); end
    for (int c = 0; c < 5; c++) begin
      y_ready = 1'b0;
      start = (c == 2); n_terms = 9'd1; bias_in = 16'h7777;
      tick();
      start = 1'b0;
      n_cmp++; if (y_valid !== 1'b1 || y_out !== ey || y_sat !== es) begin
        n_err++; $display("FAIL bp_hold_%0d: got %b/%h/%b expected 1/%h/%b", c, y_valid, y_out, y_sat, ey, es);
      end
    end
    en = 1'b0; y_ready = 1'b1; tick();
    n_cmp++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL bp_en_low_handshake: got %b expected 1", y_valid); end
    en = 1'b1; start = 1'b1; tick();
    start = 1'b0; y_ready = 1'b0;
    n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b expected 0", y_valid); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_start_ignored: got %b expected 0", busy); end
  endtask

  task automatic test_enable_stall();
    int lat; logic [15:0] ey; logic es;
    prod_q = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    ref_model(16'hF00D, ey, es);
    start = 1'b1; n_terms = 9'd4; bias_in = 16'hF00D;
    tick(); start = 1'b0;
    prod_valid = 1'b1; prod_in = prod_q[0]; tick();
    en = 1'b0; prod_in = 32'h7FFFFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (prod_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL stall_%0d: got ready %b busy %b expected 0/1", c, prod_ready, busy);
      end
    end
    en = 1'b1; prod_valid = 1'b0; tick(); tick();
    for (int i = 1; i < 4; i++) begin
      prod_valid = 1'b1; prod_in = prod_q[i]; tick();
      prod_valid = 1'b0; if (i == 2) tick();
    end
    lat = 1;
    while (!y_valid && lat < 40) begin tick(); lat++; end
    n_cmp++; if (y_out !== ey || y_sat !== es || y_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_sum: got %b/%h/%b expected 1/%h/%b", y_valid, y_out, y_sat, ey, es);
    end
    y_ready = 1'b1; tick(); y_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat; logic [15:0] y, ey; logic s, es;
    start = 1'b1; n_terms = 9'd4; bias_in = 16'h2345;
    tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin prod_valid = 1'b1; prod_in = $urandom; tick(); end
    prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (y_valid !== 1'b0 || y_out !== 16'h0000 || y_sat !== 1'b0 || busy !== 1'b0 || prod_ready !== 1'b0) begin
      n_err++; $display("FAIL arst_outputs: got v%b y%h s%b b%b r%b expected all zero", y_valid, y_out, y_sat, busy, prod_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    prod_q = {};
    ref_model(16'hABCD, ey, es);
    run_job(16'hABCD, 1'b0, 1'b1, lat, y, s);
    n_cmp++; if (y !== ey || s !== es) begin n_err++; $display("FAIL arst_bias_only: got %h/%b expected %h/%b", y, s, ey, es); end
    prod_q = {32'($urandom)};
    ref_model(16'h0400, ey, es);
    run_job(16'h0400, 1'b0, 1'b1, lat, y, s);
    n_cmp++; if (y !== ey || s !== es) begin n_err++; $display("FAIL arst_no_residue: got %h/%b expected %h/%b", y, s, ey, es); end
  endtask

  task automatic test_random();
    int lat, n; logic [15:0] y, ey, b; logic s, es;
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 8);
      b = 16'($urandom);
      prod_q = {};
      for (int i = 0; i < n; i++) begin
        if (k % 2 == 0) prod_q.push_back(32'($urandom));
        else prod_q.push_back(32'($signed(16'($urandom))) <<< $urandom_range(0, 12));
      end
      ref_model(b, ey, es);
      run_job(b, 1'b1, 1'b1, lat, y, s);
      n_cmp++; if (y !== ey || s !== es) begin n_err++; $display("FAIL rand_%0d: got %h/%b expected %h/%b", k, y, s, ey, es); end
      n_cmp++; if (lat != 2) begin n_err++; $display("FAIL rand_lat_%0d: got %0d expected 2", k, lat); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; n_terms = 9'd0; bias_in = 16'h0000;
    prod_valid = 1'b0; prod_in = 32'h0; y_ready = 1'b0;
    repeat (2) tick();
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_zero_terms();
    test_backpressure();
    test_enable_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
